// File: rtl/soc_nios2_oci_pkg.sv
// rtl/soc_nios2_oci_pkg.sv - shared types and sizing for the OCI DCT packing path
package soc_nios2_oci_pkg;

  localparam int ATOM_W    = 2;
  localparam int MAX_ATOMS = 15;
  localparam int BUF_W     = ATOM_W * MAX_ATOMS;
  localparam int CNT_W     = $clog2(MAX_ATOMS + 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [BUF_W-1:0] buffer;
    logic [CNT_W-1:0] count;
  } frame_t;

endpackage

// File: rtl/soc_nios2_oci_dct_shifter.sv
// rtl/soc_nios2_oci_dct_shifter.sv - DCT packing register and atom counter
// post_* expose this cycle's value including any atom being shifted in.
module soc_nios2_oci_dct_shifter
  import soc_nios2_oci_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [ATOM_W-1:0] atom_data,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic [BUF_W-1:0]  post_buffer,
  output logic [CNT_W-1:0]  post_count
);

  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    post_buffer = buffer_q;
    post_count  = count_q;
    if (shift_en) begin
      post_buffer = {buffer_q[BUF_W-ATOM_W-1:0], atom_data};
      post_count  = count_q + CNT_W'(1);
    end
    buffer_d = clear ? '0 : post_buffer;
    count_d  = clear ? '0 : post_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer_q <= '0;
      count_q  <= '0;
    end else begin
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

  assign dct_buffer = buffer_q;
  assign dct_count  = count_q;

endmodule

// File: rtl/soc_nios2_oci_dct_pack_ctrl.sv
// rtl/soc_nios2_oci_dct_pack_ctrl.sv - DCT atom packing sequencer with end-of-test status
// Frames are launched from post-accept values so a full or flushed frame lands one cycle later.
module soc_nios2_oci_dct_pack_ctrl
  import soc_nios2_oci_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              flush_req,
  input  logic              end_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_buffer,
  output logic [CNT_W-1:0]  out_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  frame_t out_frame_q, out_frame_d;
  logic   test_ending_q, test_ending_d;
  logic   test_has_ended_q, test_has_ended_d;

  logic             accept;
  logic             clear;
  logic             trigger;
  logic [BUF_W-1:0] post_buffer;
  logic [CNT_W-1:0] post_count;

  assign atom_ready = (state_q == ST_FILL) && !test_ending_q;
  assign accept     = atom_valid && atom_ready;

  soc_nios2_oci_dct_shifter u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .shift_en    (accept),
    .clear       (clear),
    .atom_data   (atom_data),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .post_buffer (post_buffer),
    .post_count  (post_count)
  );

  assign trigger = (post_count == CNT_W'(MAX_ATOMS)) ||
                   ((flush_req || end_req) && (post_count != '0));

  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q;
    out_frame_d      = out_frame_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;
    clear            = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (end_req) test_ending_d = 1'b1;
        if (trigger) begin
          out_frame_d = '{buffer: post_buffer, count: post_count};
          out_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else if (end_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_EMIT: begin
        if (end_req) test_ending_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          clear       = 1'b1;
          // An end arriving on the handshake edge must still drain, not strand us in FILL.
          state_d     = (test_ending_q || end_req) ? ST_DRAIN : ST_FILL;
        end
      end
      ST_DRAIN: begin
        state_d          = ST_DONE;
        test_has_ended_d = 1'b1;
      end
      ST_DONE: ;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_FILL;
      out_valid_q      <= 1'b0;
      out_frame_q      <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      out_frame_q      <= out_frame_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_buffer     = out_frame_q.buffer;
  assign out_count      = out_frame_q.count;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_soc_nios2_oci_dct_pack_ctrl.sv
// tb/tb_soc_nios2_oci_dct_pack_ctrl.sv - scoreboard bench for the DCT packing sequencer
module tb_soc_nios2_oci_dct_pack_ctrl;
  import soc_nios2_oci_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              atom_valid;
  logic [ATOM_W-1:0] atom_data;
  logic              atom_ready;
  logic              flush_req;
  logic              end_req;
  logic              out_valid;
  logic              out_ready;
  logic [BUF_W-1:0]  out_buffer;
  logic [CNT_W-1:0]  out_count;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              test_has_ended;

  int errors = 0;
  int checks = 0;

  frame_t           sb_q[$];
  frame_t           exp_f;
  logic [BUF_W-1:0] mdl_buf;
  int               mdl_cnt;

  always #5 clk = ~clk;

  soc_nios2_oci_dct_pack_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush_req      (flush_req),
    .end_req        (end_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_buffer     (out_buffer),
    .out_count      (out_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  // Every frame handed over downstream is compared against the model's queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got buffer=%h count=%0d, required no frame", out_buffer, out_count);
      end else begin
        exp_f = sb_q.pop_front();
        if (out_buffer !== exp_f.buffer || out_count !== exp_f.count) begin
          errors++;
          $display("FAIL frame_data: got buffer=%h count=%0d, required buffer=%h count=%0d",
                   out_buffer, out_count, exp_f.buffer, exp_f.count);
        end
      end
    end
  end

  task automatic mdl_emit();
    if (mdl_cnt != 0) sb_q.push_back('{buffer: mdl_buf, count: CNT_W'(mdl_cnt)});
    mdl_buf = '0;
    mdl_cnt = 0;
  endtask

  task automatic mdl_atom(input logic [ATOM_W-1:0] d);
    mdl_buf = {mdl_buf[BUF_W-ATOM_W-1:0], d};
    mdl_cnt++;
    if (mdl_cnt == MAX_ATOMS) mdl_emit();
  endtask

  task automatic send_atom(input logic [ATOM_W-1:0] d, input logic with_flush);
    atom_valid = 1'b1;
    atom_data  = d;
    flush_req  = with_flush;
    @(posedge clk); #1;
    mdl_atom(d);
    if (with_flush) mdl_emit();
    atom_valid = 1'b0;
    flush_req  = 1'b0;
  endtask

  task automatic wait_handshake(input string name);
    int n = 0;
    while (out_valid !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake_timeout: out_valid=%b after %0d cycles, required 0", name, out_valid, n);
    end
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    atom_valid = 1'b0;
    atom_data  = '0;
    flush_req  = 1'b0;
    end_req    = 1'b0;
    out_ready  = 1'b1;
    sb_q.delete();
    mdl_buf = '0;
    mdl_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_buffer !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b buffer=%h count=%0d, required 0/0/0", out_valid, out_buffer, out_count);
    end
    checks++;
    if (dct_buffer !== '0 || dct_count !== '0) begin
      errors++;
      $display("FAIL reset_dct: got buffer=%h count=%0d, required 0/0", dct_buffer, dct_count);
    end
    checks++;
    if (test_ending !== 1'b0 || test_has_ended !== 1'b0 || atom_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got ending=%b ended=%b ready=%b, required 0/0/1", test_ending, test_has_ended, atom_ready);
    end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < MAX_ATOMS; i++) send_atom(ATOM_W'(i % 4), 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd15 || out_buffer !== 30'h06C6C6C6) begin
      errors++;
      $display("FAIL full_frame: got valid=%b count=%0d buffer=%h, required 1/15/06c6c6c6", out_valid, out_count, out_buffer);
    end
    wait_handshake("full");
    checks++;
    if (dct_count !== '0 || atom_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after: got dct_count=%0d ready=%b, required 0/1", dct_count, atom_ready);
    end
  endtask

  task automatic test_partial_flush();
    send_atom(2'd3, 1'b0);
    send_atom(2'd2, 1'b0);
    send_atom(2'd1, 1'b0);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    mdl_emit();
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd3 || out_buffer !== 30'h39) begin
      errors++;
      $display("FAIL partial_flush: got valid=%b count=%0d buffer=%h, required 1/3/00000039", out_valid, out_count, out_buffer);
    end
    wait_handshake("partial");
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_flush: got out_valid=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [BUF_W-1:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < MAX_ATOMS; i++) send_atom(ATOM_W'($urandom_range(0, 3)), 1'b0);
    held = sb_q[0].buffer;
    atom_valid = 1'b1;
    atom_data  = 2'd1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_buffer !== held || atom_ready !== 1'b0 || dct_count !== 4'd15) begin
        errors++;
        $display("FAIL backpressure_hold: got valid=%b buffer=%h ready=%b dct_count=%0d, required 1/%h/0/15",
                 out_valid, out_buffer, atom_ready, dct_count, held);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    atom_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || atom_ready !== 1'b1 || dct_count !== '0) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b ready=%b dct_count=%0d, required 0/1/0", out_valid, atom_ready, dct_count);
    end
  endtask

  task automatic test_flush_with_atom();
    for (int i = 0; i < 13; i++) send_atom(ATOM_W'($urandom_range(0, 3)), 1'b0);
    send_atom(2'd2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd14) begin
      errors++;
      $display("FAIL flush_14th: got valid=%b count=%0d, required 1/14", out_valid, out_count);
    end
    wait_handshake("flush14");
  endtask

  task automatic test_end_of_test();
    int n = 0;
    for (int i = 0; i < 5; i++) send_atom(ATOM_W'(i), 1'b0);
    end_req = 1'b1;
    @(posedge clk); #1;
    end_req = 1'b0;
    mdl_emit();
    checks++;
    if (test_ending !== 1'b1 || atom_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== 4'd5) begin
      errors++;
      $display("FAIL end_emit: got ending=%b ready=%b valid=%b count=%0d, required 1/0/1/5",
               test_ending, atom_ready, out_valid, out_count);
    end
    @(posedge clk); #1;
    checks++;
    if (test_has_ended !== 1'b0) begin
      errors++;
      $display("FAIL end_drain: got test_has_ended=%b in drain, required 0", test_has_ended);
    end
    @(posedge clk); #1;
    checks++;
    if (test_has_ended !== 1'b1) begin
      errors++;
      $display("FAIL end_done: got test_has_ended=%b, required 1", test_has_ended);
    end
    atom_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flush_req = i[0];
      end_req   = ~i[0];
      @(posedge clk); #1;
      n++;
    end
    atom_valid = 1'b0;
    flush_req  = 1'b0;
    end_req    = 1'b0;
    checks++;
    if (dct_count !== '0 || out_valid !== 1'b0 || atom_ready !== 1'b0 || test_ending !== 1'b1 || test_has_ended !== 1'b1) begin
      errors++;
      $display("FAIL done_absorb: got dct_count=%0d valid=%b ready=%b ending=%b ended=%b after %0d cycles, required 0/0/0/1/1",
               dct_count, out_valid, atom_ready, test_ending, test_has_ended, n);
    end
  endtask

  task automatic test_flush_and_end();
    int n = 0;
    send_atom(2'd1, 1'b0);
    send_atom(2'd3, 1'b0);
    flush_req = 1'b1;
    end_req   = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    end_req   = 1'b0;
    mdl_emit();
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd2 || test_ending !== 1'b1) begin
      errors++;
      $display("FAIL flush_end_emit: got valid=%b count=%0d ending=%b, required 1/2/1", out_valid, out_count, test_ending);
    end
    while (test_has_ended !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (test_has_ended !== 1'b1 || n != 2) begin
      errors++;
      $display("FAIL flush_end_done: got ended=%b after %0d cycles, required 1 after 2", test_has_ended, n);
    end
  endtask

  task automatic test_reset_mid_emit();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_atom(2'd3, i == 3);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_emit_setup: got out_valid=%b, required 1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    sb_q.delete();
    mdl_buf = '0;
    mdl_cnt = 0;
    checks++;
    if (out_valid !== 1'b0 || dct_count !== '0 || test_ending !== 1'b0 || test_has_ended !== 1'b0) begin
      errors++;
      $display("FAIL mid_emit_reset: got valid=%b dct_count=%0d ending=%b ended=%b, required 0/0/0/0",
               out_valid, dct_count, test_ending, test_has_ended);
    end
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < MAX_ATOMS; i++) send_atom(ATOM_W'($urandom_range(0, 3)), 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd15) begin
      errors++;
      $display("FAIL resume_fill: got valid=%b count=%0d, required 1/15", out_valid, out_count);
    end
    wait_handshake("resume");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_flush();
    test_backpressure();
    test_flush_with_atom();
    test_end_of_test();
    apply_reset();
    test_flush_and_end();
    apply_reset();
    test_reset_mid_emit();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_nios2_oci_dct_pack_ctrl.md
Name: soc_nios2_oci_dct_pack_ctrl

Overview:
Sequences the OCI data-capture-trace (DCT) packing datapath. It accepts 2-bit trace atoms through a valid/ready interface and packs up to 15 atoms into the 30-bit dct_buffer, with dct_count giving the atom count. Full or flushed frames go to the trace-output stage through a valid/ready handshake. It also drives the test_ending and test_has_ended status pair that the OCI test bench consumes at end of simulation.

Parameters:
ATOM_W, 2, bits per trace atom
MAX_ATOMS, 15, atoms per frame (must fit in dct_count)
BUF_W, 30, frame width, fixed = ATOM_W*MAX_ATOMS
CNT_W, 4, count width, fixed = clog2(MAX_ATOMS+1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
atom_valid  in  1  trace atom offered
atom_data  in  ATOM_W  atom payload
atom_ready  out  1  atom accepted when valid&ready
flush_req  in  1  one-cycle pulse: emit partial frame
end_req  in  1  one-cycle pulse: end of test, drain and stop
out_valid  out  1  frame available downstream
out_ready  in  1  downstream accepts frame
out_buffer  out  BUF_W  frame data, stable while out_valid
out_count  out  CNT_W  atoms in frame, 1..15
dct_buffer  out  BUF_W  live packing register
dct_count  out  CNT_W  live atom count
test_ending  out  1  sticky: end requested
test_has_ended  out  1  sticky: drain complete

Behaviour:
- Reset (async assert, sync deassert handled upstream): state FILL; dct_buffer=0, dct_count=0, out_valid=0, out_buffer=0, out_count=0, test_ending=0, test_has_ended=0.
- States: FILL, EMIT, DRAIN, DONE. atom_ready=1 only in FILL and only while test_ending=0.
- Atom accept in FILL: dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom_data}; dct_count <= dct_count+1. The first atom ends up in the MSBs of a full frame.
- Emit trigger, evaluated on the post-accept count in the same cycle:
  - count reaches 15; or
  - flush_req with post-accept count >0; or
  - end_req with post-accept count >0.
  On trigger: out_buffer/out_count are loaded from the post-accept values, out_valid=1 next cycle. Latency from accepting the 15th atom to out_valid is 1 cycle.
- Partial frames are not left-justified: the low dct_count atoms are valid and the upper bits are 0.
- flush_req or end_req with count 0 and no atom accepted: no frame is emitted.
- EMIT: out_valid held until out_valid&out_ready. On that edge: out_valid=0, dct_buffer=0, dct_count=0; next state is FILL, or DRAIN if test_ending=1. flush_req in EMIT is ignored. end_req in EMIT sets test_ending; the current frame still completes.
- end_req in FILL: test_ending=1 the next cycle, atom_ready drops. With a frame pending, go to EMIT, then DRAIN; otherwise go straight to DRAIN.
- DRAIN: lasts 1 cycle, then DONE with test_has_ended=1.
- DONE: absorbing; all inputs ignored; test_ending and test_has_ended stay 1 until reset.
- Simultaneous events:
  - Atom accept plus flush in one cycle: the atom is included, then the frame is emitted.
  - Accepting the 15th atom together with flush: a single frame.
  - flush and end in the same cycle: one frame, end processing proceeds.
- Reset mid-EMIT discards the frame: out_valid drops asynchronously.
- dct_count never exceeds 15. No wrap-around is possible because atom_ready=0 whenever a frame is pending.

Decomposition:
- Shared package soc_nios2_oci_pkg holds:
  - the state enum (FILL/EMIT/DRAIN/DONE);
  - constants ATOM_W, MAX_ATOMS, BUF_W, CNT_W;
  - frame struct {buffer, count}.
- Optional sub-module soc_nios2_oci_dct_shifter owns the packing register and counter (load/shift/clear). The FSM and output register stay in the top.

Test Plan:
- Full frame: feed 15 atoms 0,1,2,3,0,... back-to-back with out_ready=1 -> out_valid 1 cycle after the 15th accept; out_count=15, out_buffer=30'h06C6C6C6 (first atom at MSBs); dct_count then returns to 0.
- Partial flush: 3 atoms (3,2,1) then flush_req -> out_count=3, out_buffer=30'h39. Flush with count 0 -> no out_valid.
- Backpressure: out_ready=0 for 10 cycles after a full frame -> out_valid/out_buffer stable, atom_ready=0, dct_count=15; release -> one handshake, then atom_ready=1.
- Simultaneous: the 14th atom accepted with flush_req in the same cycle -> one frame, out_count=14. Flush plus end in the same cycle -> one frame, then test_has_ended.
- End of test: 5 atoms, end_req -> test_ending=1 next cycle, frame out_count=5 emitted. After the handshake, test_has_ended=1 one cycle after DRAIN; further atoms and flushes are ignored.
- Reset mid-EMIT: assert reset_n=0 while out_valid=1 -> out_valid, dct_count and flags go to 0 immediately. After release, normal fill resumes.
